// File: rtl/linalg_pkg.sv
// Fixed-point linear-algebra types shared by the transform datapaths.
//   fxp_t       : signed QWI.WF scalar
//   vec4_t      : packed 4-element vector, element 3 is the homogeneous term
//   mat4_t      : packed 4x4 matrix, indexed [column][row]
//   inv_state_e : sequencing states for the inverse transform
package linalg_pkg;

    localparam int unsigned WI = 9;
    localparam int unsigned WF = 16;
    localparam int unsigned W  = WI + WF;

    typedef logic signed [W-1:0] fxp_t;
    typedef fxp_t [3:0]          vec4_t;
    typedef vec4_t [3:0]         mat4_t;

    localparam fxp_t FXP_ONE = W'(32'd1 << WF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } inv_state_e;

    // True when a wider two's-complement value, given as its top bits from
    // the target sign bit upward, would not fit in W signed bits.
    function automatic logic top_bits_ovf(input logic [3:0] top, input int unsigned n);
        logic any_diff;
        any_diff = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (i < int'(n) && top[i] != top[0]) begin
                any_diff = 1'b1;
            end
        end
        return any_diff;
    endfunction

endpackage

// File: rtl/fxp_mac_step.sv
// One multiply-accumulate step in QWI.WF.
//   a, b       : fixed-point operands
//   en, clr    : accumulator load enable; clr starts a new sum from zero
//   prod_ovf_c : shifted product did not fit in W signed bits
//   sum_c      : accumulator input (acc or 0) plus wrapped product
//   sum_ovf_c  : sum_c does not fit in W signed bits
//   acc        : registered accumulator (W+2 bits)
module fxp_mac_step
    import linalg_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           en,
    input  logic           clr,
    input  fxp_t           a,
    input  fxp_t           b,
    output logic           prod_ovf_c,
    output logic [W+1:0]   sum_c,
    output logic           sum_ovf_c,
    output logic [W+1:0]   acc
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned AW = W + 2;

    logic signed [PW-1:0] prod_full;
    logic signed [PW-1:0] prod_shr;
    logic signed [W-1:0]  prod_w;
    logic signed [AW-1:0] acc_base;

    // Full-precision product, truncated to WF fraction bits, wrapped to W.
    always_comb begin
        prod_full  = PW'($signed(a)) * PW'($signed(b));
        prod_shr   = prod_full >>> WF;
        prod_w     = prod_shr[W-1:0];
        prod_ovf_c = (prod_shr[PW-1:W-1] != {(PW-W+1){prod_shr[W-1]}});
        acc_base   = clr ? '0 : $signed(acc);
        sum_c      = acc_base + AW'(prod_w);
        sum_ovf_c  = top_bits_ovf({1'b0, sum_c[AW-1:W-1]}, 3);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/inv_transform_seq.sv
// Sequential inverse homogeneous transform p = R^T (p' - t) on one shared MAC.
//   H, p_in, in_valid, in_ready    : input transaction (H[c][r], t = H[3][0..2])
//   p_out, out_valid, out_ready    : result, p_out[3] = 1.0
//   overflow                       : sticky overflow of the current transaction
module inv_transform_seq
    import linalg_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    input  mat4_t  H,
    input  vec4_t  p_in,
    input  logic   in_valid,
    output logic   in_ready,
    output vec4_t  p_out,
    output logic   out_valid,
    input  logic   out_ready,
    output logic   overflow
);

    inv_state_e        state;
    fxp_t [2:0][2:0]   r_m;
    fxp_t [2:0]        t_v;
    fxp_t [2:0]        d_v;
    logic [1:0]        c_idx;
    logic [1:0]        r_idx;

    logic [W:0]        diff_c [3];
    logic              sub_ovf_c;

    logic              mac_en_c;
    logic              mac_clr_c;
    fxp_t              mac_a_c;
    fxp_t              mac_b_c;
    logic              prod_ovf_c;
    logic [W+1:0]      sum_c;
    logic              sum_ovf_c;
    logic [W+1:0]      mac_acc_unused;
    logic              unused_bits;

    assign unused_bits = ^{H[0][3], H[1][3], H[2][3], H[3][3], p_in[3]};

    // p' - t at one extra bit; d_v holds p' until the SUB cycle.
    always_comb begin
        sub_ovf_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            diff_c[i] = (W+1)'($signed(d_v[i])) - (W+1)'($signed(t_v[i]));
            if (diff_c[i][W] != diff_c[i][W-1]) begin
                sub_ovf_c = 1'b1;
            end
        end
    end

    // Operand selection for MAC step (c_idx, r_idx).
    always_comb begin
        mac_en_c  = (state == MAC);
        mac_clr_c = (r_idx == 2'd0);
        mac_a_c   = r_m[c_idx][r_idx];
        mac_b_c   = d_v[r_idx];
    end

    fxp_mac_step u_mac (
        .clk        (clk),
        .resetn     (resetn),
        .en         (mac_en_c),
        .clr        (mac_clr_c),
        .a          (mac_a_c),
        .b          (mac_b_c),
        .prod_ovf_c (prod_ovf_c),
        .sum_c      (sum_c),
        .sum_ovf_c  (sum_ovf_c),
        .acc        (mac_acc_unused)
    );

    // Sequencer, counters and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p_out     <= '0;
            overflow  <= 1'b0;
            r_m       <= '0;
            t_v       <= '0;
            d_v       <= '0;
            c_idx     <= 2'd0;
            r_idx     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int c = 0; c < 3; c++) begin
                            for (int r = 0; r < 3; r++) begin
                                r_m[c][r] <= H[c][r];
                            end
                            t_v[c] <= H[3][c];
                            d_v[c] <= p_in[c];
                        end
                        overflow <= 1'b0;
                        in_ready <= 1'b0;
                        c_idx    <= 2'd0;
                        r_idx    <= 2'd0;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    for (int i = 0; i < 3; i++) begin
                        d_v[i] <= diff_c[i][W-1:0];
                    end
                    if (sub_ovf_c) begin
                        overflow <= 1'b1;
                    end
                    state <= MAC;
                end
                MAC: begin
                    if (prod_ovf_c || (r_idx == 2'd2 && sum_ovf_c)) begin
                        overflow <= 1'b1;
                    end
                    if (r_idx == 2'd2) begin
                        p_out[c_idx] <= sum_c[W-1:0];
                        r_idx        <= 2'd0;
                        if (c_idx == 2'd2) begin
                            p_out[3]  <= FXP_ONE;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            c_idx <= c_idx + 2'd1;
                        end
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_transform_seq.sv
module tb_inv_transform_seq;
    import linalg_pkg::*;

    typedef struct packed {
        vec4_t p;
        logic  ovf;
    } exp_t;

    logic  clk;
    logic  resetn;
    mat4_t H;
    vec4_t p_in;
    logic  in_valid;
    logic  in_ready;
    vec4_t p_out;
    logic  out_valid;
    logic  out_ready;
    logic  overflow;

    int    n_vec;
    int    n_err;
    exp_t  sb_q[$];

    inv_transform_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .H         (H),
        .p_in      (p_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_out     (p_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint wrapw(input longint v);
        logic [63:0] tmp;
        tmp = v;
        return sx(tmp[W-1:0]);
    endfunction

    function automatic bit fits(input longint v);
        return (v >= -(longint'(1) << (W-1))) && (v < (longint'(1) << (W-1)));
    endfunction

    // Reference arithmetic: d = p' - t, p[c] = sum_r (H[c][r]*d[r]) >>> WF.
    function automatic exp_t model(input mat4_t h, input vec4_t p);
        exp_t        e;
        longint      d [3];
        longint      v;
        longint      acc;
        logic [63:0] tmp;
        e.ovf = 1'b0;
        e.p   = '0;
        for (int r = 0; r < 3; r++) begin
            v = sx(p[r]) - sx(h[3][r]);
            if (!fits(v)) e.ovf = 1'b1;
            d[r] = wrapw(v);
        end
        for (int c = 0; c < 3; c++) begin
            acc = 0;
            for (int r = 0; r < 3; r++) begin
                v = (sx(h[c][r]) * d[r]) >>> WF;
                if (!fits(v)) e.ovf = 1'b1;
                acc += wrapw(v);
            end
            if (!fits(acc)) e.ovf = 1'b1;
            tmp    = acc;
            e.p[c] = tmp[W-1:0];
        end
        e.p[3] = 25'h0010000;
        return e;
    endfunction

    function automatic fxp_t fx(input int v);
        return W'(v);
    endfunction

    function automatic mat4_t ident_t(input int t0, input int t1, input int t2);
        mat4_t h;
        h       = '0;
        h[0][0] = fx(32'h10000);
        h[1][1] = fx(32'h10000);
        h[2][2] = fx(32'h10000);
        h[3][0] = fx(t0);
        h[3][1] = fx(t1);
        h[3][2] = fx(t2);
        h[3][3] = fx(32'h10000);
        return h;
    endfunction

    function automatic vec4_t mkv(input int a, input int b, input int c);
        vec4_t v;
        v[0] = fx(a);
        v[1] = fx(b);
        v[2] = fx(c);
        v[3] = fx(32'h10000);
        return v;
    endfunction

    task automatic garbage_inputs();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) H[c][r] = W'($urandom);
            p_in[c] = W'($urandom);
        end
    endtask

    // Full transaction: push expectation, drive, check latency, pop and compare.
    task automatic do_txn(input string tag, input mat4_t h, input vec4_t p, input exp_t e,
                          input int hold, input bit pulse);
        int   n;
        int   lat;
        bit   busy_ok;
        bit   hold_ok;
        exp_t got;
        sb_q.push_back(e);
        @(negedge clk);
        H         = h;
        p_in      = p;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, 128'(n < 50), 128'(1));
        @(posedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) busy_ok = 1'b0;
            garbage_inputs();
            in_valid = pulse ? lat[0] : 1'b0;
        end while (!out_valid && lat < 40);
        chk({tag, "_latency"}, 128'(lat), 128'(11));
        chk({tag, "_in_ready_busy"}, 128'(busy_ok), 128'(1));
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'(0), 128'(1));
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_p_out"}, 128'(p_out), 128'(got.p));
            chk({tag, "_overflow"}, 128'(overflow), 128'(got.ovf));
        end
        hold_ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            garbage_inputs();
            in_valid = pulse ? k[0] : 1'b0;
            if (!out_valid || in_ready || p_out !== e.p || overflow !== e.ovf) hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 128'(hold_ok), 128'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_post_in_ready"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        mat4_t h;
        vec4_t p;
        exp_t  e;
        bit    never_valid;
        int    n;

        n_vec     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        H         = '0;
        p_in      = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_p_out", 128'(p_out), 128'(0));
        chk("reset_overflow", 128'(overflow), 128'(0));

        // Identity, t = 0.
        e.p   = mkv(32'h10000, 32'h20000, 32'h30000);
        e.ovf = 1'b0;
        do_txn("identity", ident_t(0, 0, 0), mkv(32'h10000, 32'h20000, 32'h30000), e, 0, 1'b0);

        // Pure translation t = (2.0, -1.0, 0.5).
        e.p   = mkv(32'h10000, 32'h10000, 32'h08000);
        e.ovf = 1'b0;
        do_txn("translate", ident_t(32'h20000, -32'h10000, 32'h08000),
               mkv(32'h30000, 0, 32'h10000), e, 0, 1'b0);

        // 90 degrees about z, with output held off and busy in_valid pulses.
        h       = '0;
        h[0][1] = fx(32'h10000);
        h[1][0] = fx(-32'h10000);
        h[2][2] = fx(32'h10000);
        h[3][3] = fx(32'h10000);
        e.p     = mkv(32'h10000, 0, 0);
        e.ovf   = 1'b0;
        do_txn("rot_z_hold", h, mkv(0, 32'h10000, 0), e, 5, 1'b1);

        // Subtraction overflow: 255.0 - (-255.0) wraps to -2.0.
        e.p   = mkv(32'h1FE0000, 0, 0);
        e.ovf = 1'b1;
        do_txn("sub_ovf", ident_t(-32'hFF0000, 0, 0), mkv(32'hFF0000, 0, 0), e, 2, 1'b0);

        // Clean transaction right after clears overflow.
        e.p   = mkv(32'h10000, 32'h20000, 32'h30000);
        e.ovf = 1'b0;
        do_txn("ovf_cleared", ident_t(0, 0, 0), mkv(32'h10000, 32'h20000, 32'h30000), e, 0, 1'b0);

        // Product overflow: 200.0 * 2.0 exceeds range.
        h       = ident_t(0, 0, 0);
        h[0][0] = fx(32'hC80000);
        do_txn("mul_ovf", h, mkv(32'h20000, 0, 0), model(h, mkv(32'h20000, 0, 0)), 0, 1'b0);

        // Randomised rotations/translations with a reference model.
        for (int k = 0; k < 4; k++) begin
            h = '0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) h[c][r] = fx(int'($urandom_range(0, 32'h40000)) - 32'h20000);
                h[3][c] = fx(int'($urandom_range(0, 32'h100000)) - 32'h80000);
                p[c]    = fx(int'($urandom_range(0, 32'h100000)) - 32'h80000);
            end
            h[3][3] = fx(32'h10000);
            p[3]    = fx(32'h10000);
            do_txn("random", h, p, model(h, p), k, 1'b0);
        end

        // Reset during MAC discards the transaction.
        @(negedge clk);
        H        = ident_t(32'h50000, 32'h60000, 32'h70000);
        p_in     = mkv(32'h10000, 32'h10000, 32'h10000);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_accept_timeout", 128'(n < 50), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_p_out", 128'(p_out), 128'(0));
        chk("abort_overflow", 128'(overflow), 128'(0));
        never_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) never_valid = 1'b0;
            @(negedge clk);
        end
        chk("abort_no_output", 128'(never_valid), 128'(1));

        e.p   = mkv(32'h10000, 32'h20000, 32'h30000);
        e.ovf = 1'b0;
        do_txn("after_abort", ident_t(0, 0, 0), mkv(32'h10000, 32'h20000, 32'h30000), e, 0, 1'b0);

        chk("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
